max6675_scan_ctrl: RTL and testbench

//  Scheduler that shares one MAX6675-style SPI read bus (sclk, miso) between

---
 rtl/max6675_scan_ctrl_if.sv | 25 ++
 rtl/max6675_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_max6675_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/max6675_scan_ctrl_if.sv
// Shared SPI read bus and per-channel result bundle of the MAX6675 scan controller.
// slave = controller side, master = board/consumer side.
interface max6675_scan_ctrl_if #(
    parameter int CHANNELS = 4
);
    logic                     enable;
    logic                     miso;
    logic                     sclk;
    logic [CHANNELS-1:0]      sel;
    logic [CHANNELS*12-1:0]   temperature;
    logic [CHANNELS-1:0]      valid;
    logic [CHANNELS-1:0]      fault;
    logic [3:0]               channel;
    logic                     frame_done;

    modport slave (
        input  enable, miso,
        output sclk, sel, temperature, valid, fault, channel, frame_done
    );

    modport master (
        output enable, miso,
        input  sclk, sel, temperature, valid, fault, channel, frame_done
    );
endinterface

// File: rtl/max6675_scan_ctrl.sv
// Round-robin reader of CHANNELS MAX6675 sensors on one shared sclk/miso bus.
// Frame = (34 + GAP_TICKS) ticks per channel; enable only gates the start of the next frame.
module max6675_scan_ctrl #(
    parameter int CHANNELS  = 4,
    parameter int DIVIDER   = 1000,
    parameter int GAP_TICKS = 100
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    max6675_scan_ctrl_if.slave   bus
);
    localparam int DW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, COMMIT, GAP} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           div_q, div_d;
    logic [3:0]              chan_q, chan_d;
    logic [4:0]              bit_q, bit_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic [15:0]             shreg_q, shreg_d;
    logic                    sclk_q, sclk_d;
    logic [CHANNELS-1:0]     sel_q, sel_d;
    logic [CHANNELS*12-1:0]  temp_q, temp_d;
    logic [CHANNELS-1:0]     valid_q, valid_d;
    logic [CHANNELS-1:0]     fault_q, fault_d;
    logic                    done_q, done_d;

    logic                    tick;
    logic                    fault_bit;
    logic [3:0]              chan_nxt;

    function automatic logic [CHANNELS-1:0] sel_for(input logic [3:0] ch);
        logic [CHANNELS-1:0] s;
        s = '1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == 4'(i)) s[i] = 1'b0;
        end
        return s;
    endfunction

    assign tick      = (div_q == DW'(DIVIDER - 1));
    assign div_d     = tick ? '0 : div_q + DW'(1);
    assign fault_bit = shreg_q[2] | shreg_q[15];
    assign chan_nxt  = (chan_q == 4'(CHANNELS - 1)) ? 4'd0 : chan_q + 4'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            chan_q  <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            sel_q   <= '1;
            temp_q  <= '0;
            valid_q <= '0;
            fault_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            chan_q  <= chan_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            sel_q   <= sel_d;
            temp_q  <= temp_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        sel_d   = sel_q;
        temp_d  = temp_q;
        valid_d = valid_q;
        fault_d = fault_q;
        done_d  = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    sel_d  = '1;
                    sclk_d = 1'b0;
                    if (bus.enable) begin
                        state_d = SELECT;
                        sel_d   = sel_for(chan_q);
                    end
                end
                SELECT: begin
                    state_d = SHIFT;
                    bit_d   = '0;
                end
                SHIFT: begin
                    // bit_q[0]=0 is the rising half, 1 the sampling/falling half
                    if (!bit_q[0]) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[14:0], bus.miso};
                    end
                    bit_d = bit_q + 5'd1;
                    if (bit_q == 5'd31) state_d = COMMIT;
                end
                COMMIT: begin
                    sel_d   = '1;
                    sclk_d  = 1'b0;
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (chan_q == 4'(i)) begin
                            if (!fault_bit) begin
                                temp_d[i*12 +: 12] = shreg_q[14:3];
                                valid_d[i]         = 1'b1;
                                fault_d[i]         = 1'b0;
                            end else begin
                                valid_d[i] = 1'b0;
                                fault_d[i] = 1'b1;
                            end
                        end
                    end
                end
                GAP: begin
                    sel_d = '1;
                    if (gap_q == GW'(GAP_TICKS - 1)) begin
                        chan_d = chan_nxt;
                        if (bus.enable) begin
                            state_d = SELECT;
                            sel_d   = sel_for(chan_nxt);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = '1;
                    sclk_d  = 1'b0;
                end
            endcase
        end
    end

    assign bus.sclk        = sclk_q;
    assign bus.sel         = sel_q;
    assign bus.temperature = temp_q;
    assign bus.valid       = valid_q;
    assign bus.fault       = fault_q;
    assign bus.channel     = chan_q;
    assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_max6675_scan_ctrl.sv
// Directed bench for max6675_scan_ctrl: four sensor models on the shared bus plus a bus invariant checker.
module tb_max6675_scan_ctrl;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [15:0] words [4];

    always #5 clk = ~clk;

    max6675_scan_ctrl_if #(.CHANNELS(4)) dut_if ();

    max6675_scan_ctrl #(
        .CHANNELS (4),
        .DIVIDER  (2),
        .GAP_TICKS(4)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (dut_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sensor model: first bit appears when its sel falls, next bit after each sclk fall.
    logic [3:0]  m_prev_sel = 4'hF;
    logic        m_prev_sclk = 1'b0;
    logic [15:0] m_word = '0;
    int          m_pos = 0;
    always @(negedge clk) begin
        if (reset_i) begin
            dut_if.miso = 1'b0;
        end else if (m_prev_sel == 4'hF && dut_if.sel != 4'hF) begin
            for (int i = 0; i < 4; i++) if (!dut_if.sel[i]) m_word = words[i];
            m_pos = 15;
            dut_if.miso = m_word[15];
        end else if (m_prev_sclk && !dut_if.sclk && m_pos > 0) begin
            m_pos--;
            dut_if.miso = m_word[m_pos];
        end
        m_prev_sel  = dut_if.sel;
        m_prev_sclk = dut_if.sclk;
    end

    // Bus invariants and per-frame shape; also records the order channels are selected.
    logic [3:0] c_prev_sel = 4'hF;
    logic       c_prev_sclk = 1'b0;
    int         low_len = 0;
    int         rises = 0;
    bit         aborted = 1'b0;
    int         order[$];
    always @(negedge clk) begin
        if (reset_i) aborted = 1'b1;
        check("one_sel_low", 32'($countones(~dut_if.sel) <= 1), 1);
        if (dut_if.sel == 4'hF) check("sclk_low_when_idle", 32'(dut_if.sclk), 0);
        if (c_prev_sel == 4'hF && dut_if.sel != 4'hF) begin
            low_len = 0;
            rises   = 0;
            aborted = reset_i;
            for (int i = 0; i < 4; i++) if (!dut_if.sel[i]) order.push_back(i);
        end
        if (dut_if.sel != 4'hF) begin
            low_len++;
            if (dut_if.sclk && !c_prev_sclk) rises++;
        end
        if (c_prev_sel != 4'hF && dut_if.sel == 4'hF && !aborted) begin
            check("frame_sel_low_clks", 32'(low_len), 68);
            check("frame_sclk_rises", 32'(rises), 16);
        end
        c_prev_sel  = dut_if.sel;
        c_prev_sclk = dut_if.sclk;
    end

    task automatic wait_frame(input string tag);
        int n = 0;
        while (dut_if.frame_done !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_frame_seen"}, 32'(n < 400), 1);
    endtask

    task automatic wait_sel(input string tag, input logic [3:0] want);
        int n = 0;
        while (dut_if.sel !== want && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_sel_seen"}, 32'(n < 400), 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sclk"}, 32'(dut_if.sclk), 0);
        check({tag, "_sel"}, 32'(dut_if.sel), 32'hF);
        check({tag, "_temp_lo"}, dut_if.temperature[31:0], 0);
        check({tag, "_temp_hi"}, 32'(dut_if.temperature[47:32]), 0);
        check({tag, "_valid"}, 32'(dut_if.valid), 0);
        check({tag, "_fault"}, 32'(dut_if.fault), 0);
        check({tag, "_channel"}, 32'(dut_if.channel), 0);
        check({tag, "_frame_done"}, 32'(dut_if.frame_done), 0);
    endtask

    initial begin
        int exp_order [5];
        int n;
        int r;
        logic prev;

        exp_order = '{0, 1, 2, 3, 0};
        words[0] = 16'h0C80;
        words[1] = 16'h1000;
        words[2] = 16'h7FF8;
        words[3] = 16'h0C80;
        dut_if.enable = 1'b0;
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset_i = 1'b0;

        // good read on ch0
        dut_if.enable = 1'b1;
        wait_frame("good0");
        check("good0_channel", 32'(dut_if.channel), 0);
        check("good0_temp", 32'(dut_if.temperature[11:0]), 32'h190);
        check("good0_valid", 32'(dut_if.valid[0]), 1);
        check("good0_fault", 32'(dut_if.fault[0]), 0);
        words[0] = 16'h0008;
        @(posedge clk);
        #1;
        check("good0_done_one_clk", 32'(dut_if.frame_done), 0);

        // round robin ch1..ch3, then wrap to ch0
        wait_frame("rr1");
        check("rr1_channel", 32'(dut_if.channel), 1);
        check("rr1_temp", 32'(dut_if.temperature[23:12]), 32'h200);
        check("rr1_valid", 32'(dut_if.valid), 32'h3);
        check("rr1_ch0_held", 32'(dut_if.temperature[11:0]), 32'h190);
        words[1] = 16'h0C80;
        @(posedge clk);
        #1;
        wait_frame("rr2");
        check("rr2_channel", 32'(dut_if.channel), 2);
        check("rr2_temp", 32'(dut_if.temperature[35:24]), 32'hFFF);
        @(posedge clk);
        #1;
        wait_frame("rr3");
        check("rr3_channel", 32'(dut_if.channel), 3);
        check("rr3_temp", 32'(dut_if.temperature[47:36]), 32'h190);
        check("rr3_valid", 32'(dut_if.valid), 32'hF);
        @(posedge clk);
        #1;
        wait_frame("rr0");
        check("rr0_channel_wrap", 32'(dut_if.channel), 0);
        check("rr0_temp", 32'(dut_if.temperature[11:0]), 32'h001);
        @(posedge clk);
        #1;

        // ch1 good 0x0C80, then open thermocouple, then dummy bit set
        wait_frame("f1good");
        check("f1good_temp", 32'(dut_if.temperature[23:12]), 32'h190);
        check("f1good_valid", 32'(dut_if.valid[1]), 1);
        words[1] = 16'h0C84;
        @(posedge clk);
        #1;
        repeat (3) begin
            wait_frame("f_skip");
            @(posedge clk);
            #1;
        end
        wait_frame("f1open");
        check("f1open_channel", 32'(dut_if.channel), 1);
        check("f1open_fault", 32'(dut_if.fault[1]), 1);
        check("f1open_valid", 32'(dut_if.valid[1]), 0);
        check("f1open_temp_held", 32'(dut_if.temperature[23:12]), 32'h190);
        check("f1open_others_valid", 32'(dut_if.valid), 32'hD);
        words[1] = 16'h8000;
        @(posedge clk);
        #1;
        repeat (3) begin
            wait_frame("f_skip");
            @(posedge clk);
            #1;
        end
        wait_frame("f1dummy");
        check("f1dummy_channel", 32'(dut_if.channel), 1);
        check("f1dummy_fault", 32'(dut_if.fault[1]), 1);
        check("f1dummy_valid", 32'(dut_if.valid[1]), 0);

        // drop enable in the middle of ch2's shift
        words[2] = 16'h0010;
        wait_sel("en_ch2", 4'b1011);
        repeat (12) @(posedge clk);
        #1;
        dut_if.enable = 1'b0;
        wait_frame("en_ch2");
        check("en_ch2_channel", 32'(dut_if.channel), 2);
        check("en_ch2_temp", 32'(dut_if.temperature[35:24]), 32'h002);
        repeat (20) @(posedge clk);
        #1;
        check("en_idle_channel", 32'(dut_if.channel), 3);
        n = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (dut_if.sel != 4'hF || dut_if.sclk) n++;
        end
        check("en_idle_quiet", 32'(n), 0);
        words[3] = 16'h0640;
        dut_if.enable = 1'b1;
        wait_sel("en_resume", 4'b0111);
        wait_frame("en_ch3");
        check("en_ch3_channel", 32'(dut_if.channel), 3);
        check("en_ch3_temp", 32'(dut_if.temperature[47:36]), 32'h0C8);
        @(posedge clk);
        #1;

        // reset in the middle of ch1 (after 7 sclk rises)
        wait_sel("rst_ch1", 4'b1101);
        n = 0;
        r = 0;
        prev = dut_if.sclk;
        while (r < 7 && n < 200) begin
            @(posedge clk);
            #1;
            if (dut_if.sclk && !prev) r++;
            prev = dut_if.sclk;
            n++;
        end
        check("rst_bit7_reached", 32'(r), 7);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("rst_mid");
        reset_i = 1'b0;
        wait_sel("rst_restart", 4'b1110);
        check("rst_restart_channel", 32'(dut_if.channel), 0);
        wait_frame("rst_ch0");
        check("rst_ch0_temp", 32'(dut_if.temperature[11:0]), 32'h001);
        check("rst_ch0_valid", 32'(dut_if.valid), 32'h1);

        check("order_len", 32'(order.size() >= 5), 1);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) check("sel_order", 32'(order[i]), 32'(exp_order[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
